// File: rtl/div_pkg.sv
// Shared types for the iterative divider: request opcodes, FSM states, step count.
// WORKAROUND_X_VALUES adds an explicit STATE_X encoding to the state enum.
`ifndef XLEN
`define XLEN 64
`endif

package div;

  localparam int unsigned DIV_STEPS = `XLEN;

  typedef enum logic {
    DIV,
    DIVU
  } op_t;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
`ifdef WORKAROUND_X_VALUES
    , STATE_X
`endif
  } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring division iteration: shift {rem, quo} left, subtract divisor if it fits.
module div_step #(
  parameter int unsigned XLEN_P = 64
) (
  input  logic [XLEN_P-1:0] rem_i,
  input  logic [XLEN_P-1:0] quo_i,
  input  logic [XLEN_P-1:0] div_i,
  output logic [XLEN_P-1:0] rem_o,
  output logic [XLEN_P-1:0] quo_o
);

  // One extra bit: a shifted partial remainder can exceed XLEN_P bits for DIVU.
  logic [XLEN_P:0] shifted;
  logic            fits;

  assign shifted = {rem_i, quo_i[XLEN_P-1]};
  assign fits    = (shifted >= {1'b0, div_i});

  always_comb begin
    rem_o = shifted[XLEN_P-1:0];
    quo_o = {quo_i[XLEN_P-2:0], 1'b0};
    if (fits) begin
      rem_o = shifted[XLEN_P-1:0] - div_i;
      quo_o = {quo_i[XLEN_P-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider with RISC-V DIV/DIVU semantics, one request at a time.
// DIV_FAST_SPECIAL_EN: divide-by-zero, signed overflow and |a|<|b| bypass the iteration.
module div_unit
  import div::*;
#(
  parameter int unsigned XLEN_P = `XLEN
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  op_t               op,
  input  logic [XLEN_P-1:0] dividend,
  input  logic [XLEN_P-1:0] divisor,
  input  logic              kill,
  output logic              busy,
  output logic              done,
  output logic [XLEN_P-1:0] quotient,
  output logic [XLEN_P-1:0] remainder
);

  localparam int unsigned CNT_W = $clog2(XLEN_P);
  localparam logic [XLEN_P-1:0] MIN_NEG = {1'b1, {(XLEN_P-1){1'b0}}};

  state_t            state_q;
  logic              signed_q;
  logic              sign_a_q;
  logic              sign_b_q;
  logic              ovf_q;
  logic [XLEN_P-1:0] a_raw_q;
  logic [XLEN_P-1:0] abs_b_q;
  logic [XLEN_P-1:0] rem_q;
  logic [XLEN_P-1:0] quo_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              busy_q;
  logic              done_q;
  logic [XLEN_P-1:0] quotient_q;
  logic [XLEN_P-1:0] remainder_q;

  logic              is_signed;
  logic              neg_a;
  logic              neg_b;
  logic [XLEN_P-1:0] abs_a;
  logic [XLEN_P-1:0] abs_b;
  logic              ovf_in;
  logic [XLEN_P-1:0] step_rem_d;
  logic [XLEN_P-1:0] step_quo_d;
  logic [XLEN_P-1:0] fix_q_d;
  logic [XLEN_P-1:0] fix_r_d;

  assign is_signed = (op == DIV);
  assign neg_a     = is_signed & dividend[XLEN_P-1];
  assign neg_b     = is_signed & divisor[XLEN_P-1];
  assign abs_a     = neg_a ? -dividend : dividend;
  assign abs_b     = neg_b ? -divisor  : divisor;
  assign ovf_in    = is_signed && (dividend == MIN_NEG) && (divisor == '1);

`ifdef DIV_FAST_SPECIAL_EN
  logic fast_in;
  assign fast_in = (divisor == '0) | ovf_in | (abs_a < abs_b);
`endif

  div_step #(.XLEN_P(XLEN_P)) u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .div_i (abs_b_q),
    .rem_o (step_rem_d),
    .quo_o (step_quo_d)
  );

  // Special cases override the sign-fixed magnitudes; zero divisor returns the raw dividend.
  always_comb begin
    fix_q_d = (signed_q && (sign_a_q ^ sign_b_q)) ? -quo_q : quo_q;
    fix_r_d = (signed_q && sign_a_q) ? -rem_q : rem_q;
    if (abs_b_q == '0) begin
      fix_q_d = '1;
      fix_r_d = a_raw_q;
    end else if (ovf_q) begin
      fix_q_d = a_raw_q;
      fix_r_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      signed_q    <= 1'b0;
      sign_a_q    <= 1'b0;
      sign_b_q    <= 1'b0;
      ovf_q       <= 1'b0;
      a_raw_q     <= '0;
      abs_b_q     <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (kill) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (start) begin
              signed_q <= is_signed;
              sign_a_q <= neg_a;
              sign_b_q <= neg_b;
              ovf_q    <= ovf_in;
              a_raw_q  <= dividend;
              abs_b_q  <= abs_b;
              cnt_q    <= CNT_W'(XLEN_P - 1);
              busy_q   <= 1'b1;
`ifdef DIV_FAST_SPECIAL_EN
              // Bypassed requests preload the trivial result q=0, r=|a| for the sign fix.
              if (fast_in) begin
                state_q <= FIX;
                rem_q   <= abs_a;
                quo_q   <= '0;
              end else begin
                state_q <= CALC;
                rem_q   <= '0;
                quo_q   <= abs_a;
              end
`else
              state_q <= CALC;
              rem_q   <= '0;
              quo_q   <= abs_a;
`endif
            end
          end
          CALC: begin
            rem_q <= step_rem_d;
            quo_q <= step_quo_d;
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == '0) state_q <= FIX;
          end
          FIX: begin
            quotient_q  <= fix_q_d;
            remainder_q <= fix_r_d;
            done_q      <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative radix-2 restoring divider. It is the responder side of the execute stage's divide interface.
- Accepts a div::op_t request (DIV/DIVU) with two XLEN operands and returns quotient and remainder. The execute stage selects these through result_select_t DIV_Q/DIV_R.
- Follows RISC-V M-extension semantics, including the divide-by-zero and signed-overflow results.
- Single request outstanding; no pipelining.

Parameters:
- XLEN_P, default `XLEN (64): operand and result width.

Ports:
- clk  in  1  clock.
- reset_n  in  1  synchronous, active-low reset.
- start  in  1  request strobe; accepted only when busy=0.
- op  in  div::op_t  DIV (signed) or DIVU (unsigned).
- dividend  in  XLEN_P  operand a.
- divisor  in  XLEN_P  operand b.
- kill  in  1  abort the in-flight operation (pipeline flush).
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse; results valid this cycle.
- quotient  out  XLEN_P  result q.
- remainder  out  XLEN_P  result r.

Behaviour:
- Reset (reset_n=0 at a posedge):
  - state goes to IDLE.
  - busy=0, done=0, quotient=0, remainder=0.
  - Overrides any in-flight op, start and kill.
- IDLE: start=1 at edge E0 captures the request.
  - Latch op, the sign of each operand, and abs(dividend) and abs(divisor). DIVU takes the raw values as the absolutes.
  - Counter goes to XLEN_P-1; state goes to CALC; busy=1 after E0.
- CALC: one restoring step per edge.
  - Shift {rem, quo} left by 1.
  - If rem >= |b|: rem -= |b| and set the quotient LSB.
  - The counter decrements. When the step with counter=0 completes, state goes to FIX.
  - For XLEN_P=64, the steps occupy edges E1..E64.
- FIX (edge E65): apply signs and drive outputs.
  - Sign fix, DIV only: quotient is negated if sign(a) XOR sign(b); remainder takes sign(a).
  - Divide by zero (b=0): quotient=all ones, remainder=a (raw a, not abs), for both DIV and DIVU.
  - Signed overflow (DIV, a=100..0, b=all ones): quotient=a, remainder=0.
  - After E65: done=1 for exactly one cycle, busy=0, state goes to IDLE.
- Total latency: done is observed in the cycle after E65, i.e. 66 edges after acceptance.
- Results hold their value until the next done. They are not cleared by a new start.
- start while busy=1 is ignored; no queueing.
- start in the same cycle done=1 is accepted, because state is already IDLE. Back-to-back issue gives a 66-cycle period.
- kill=1 (busy=1 or FIX):
  - State goes to IDLE at that edge; busy=0 after; no done pulse; outputs retain their previous values.
  - kill while IDLE has no effect.
  - kill together with start while IDLE: kill wins and the request is dropped.
- Operand inputs are sampled only at acceptance. Changes afterwards do not affect the result.

Optional Feature:
- Macro DIV_FAST_SPECIAL_EN.
- Defined:
  - Divide-by-zero and signed-overflow are detected at acceptance.
  - State goes directly to FIX, so done is observed 2 cycles after acceptance and CALC is skipped.
  - Also, if |a| < |b| (non-zero b), the result is q=0, r=a with the same 2-cycle latency.
- Undefined: all requests take the full 66 cycles. Special-case results are identical, produced by the override in FIX.

Decomposition:
- Add to package div:
  - DIV_STEPS constant (= `XLEN).
  - state_t enum: IDLE, CALC, FIX.
  - For the `WORKAROUND_X_VALUES style, include STATE_X.
- Sub-module div_step: combinational single restoring iteration.
  - Inputs rem, quo, abs divisor.
  - Outputs next rem and next quo.
  - Keeps the iteration independently testable.
- Sign handling stays in div_unit.

Test Plan:
- DIVU 100 / 7 → after 66 cycles done=1; quotient=14, remainder=2; busy high for cycles 1..65 only.
- DIV -7 / 2 → quotient=0xFFFF_FFFF_FFFF_FFFD (-3), remainder=0xFFFF_FFFF_FFFF_FFFF (-1); DIV 7 / -2 → q=-3, r=1.
- Divide by zero: DIVU 5/0 → q=0xFFFF_FFFF_FFFF_FFFF, r=5. DIV -5/0 → q=all ones, r=0xFFFF_FFFF_FFFF_FFFB. Latency is 66 cycles, or 2 with DIV_FAST_SPECIAL_EN.
- Overflow: DIV 0x8000_0000_0000_0000 / 0xFFFF_FFFF_FFFF_FFFF → q=0x8000_0000_0000_0000, r=0.
- Busy/kill handling:
  - start DIVU 9/3 while busy with 100/7 is ignored; the single done carries 14/2.
  - kill at cycle 30 of a request → no done, busy=0 next cycle.
  - A new start of 9/3 then completes with q=3, r=0.
- Reset handling:
  - reset_n=0 mid-CALC → next cycle busy=0, done=0, q=r=0.
  - start DIVU 1/1 issued in the same cycle as a prior done is accepted and yields q=1, r=0.
